// File: rtl/slc3_datapath_p_pkg.sv
// Shared types, bus-source encodings and sign-extension helper for the SLC-3 datapath.
package slc3_pkg;

  typedef enum logic [1:0] {PC_INC = 2'd0, PC_BUS = 2'd1, PC_ADDR = 2'd2, PC_HOLD = 2'd3} pcmux_t;
  typedef enum logic [1:0] {A2_ZERO = 2'd0, A2_OFF6 = 2'd1, A2_OFF9 = 2'd2, A2_OFF11 = 2'd3} addr2mux_t;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_AND = 2'd1, ALU_NOT = 2'd2, ALU_PASSA = 2'd3} alu_op_t;

  // Gate vector order is {GateMARMUX, GateALU, GateMDR, GatePC}.
  localparam logic [3:0] SRC_PC     = 4'b0001;
  localparam logic [3:0] SRC_MDR    = 4'b0010;
  localparam logic [3:0] SRC_ALU    = 4'b0100;
  localparam logic [3:0] SRC_MARMUX = 4'b1000;

  localparam logic [2:0] NZP_RESET = 3'b010;
  localparam int unsigned SEXT_W = 64;

  // Sign-extend the low src_w bits of x to SEXT_W bits; callers truncate to WIDTH.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] x, input int unsigned src_w);
    logic [SEXT_W-1:0] shl;
    shl = x << (SEXT_W - src_w);
    return SEXT_W'($signed(shl) >>> (SEXT_W - src_w));
  endfunction

endpackage

// File: rtl/slc3_datapath_p_if.sv
// Control/status bundle between the ISDU (master) and the datapath (slave).
interface slc3_datapath_p_if #(parameter int unsigned WIDTH = 16);
  logic             LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic             GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]       PCMUX, ADDR2MUX, ALUK;
  logic             DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [WIDTH-1:0] MDR_In;
  logic [WIDTH-1:0] Bus, MAR, MDR, IR, PC;
  logic             BEN;
  logic [11:0]      LED;
  logic             BusErr, BusErrSticky;

  modport master (
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, MDR_In,
    input  Bus, MAR, MDR, IR, PC, BEN, LED, BusErr, BusErrSticky
  );

  modport slave (
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, MDR_In,
    output Bus, MAR, MDR, IR, PC, BEN, LED, BusErr, BusErrSticky
  );
endinterface

// File: rtl/slc3_datapath_p_reg_file.sv
// 8-entry register file: two asynchronous read ports, one synchronous write port.
module slc3_reg_file #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [2:0]       i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [2:0]       i_raddr1,
  input  logic [2:0]       i_raddr2,
  output logic [WIDTH-1:0] o_rdata1_c,
  output logic [WIDTH-1:0] o_rdata2_c
);
  localparam int unsigned NREGS = 8;

  logic [WIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads see pre-edge contents, so a same-cycle write is not forwarded.
  assign o_rdata1_c = r_mem[i_raddr1];
  assign o_rdata2_c = r_mem[i_raddr2];
endmodule

// File: rtl/slc3_datapath_p.sv
// LC-3 architectural state and CPU bus; all loads are driven by the ISDU control word.
module slc3_datapath_p
  import slc3_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input logic          Clk,
  input logic          Reset,
  slc3_datapath_p_if.slave dp
);
  logic [WIDTH-1:0] r_pc, r_mar, r_mdr, r_ir;
  logic [2:0]       r_nzp;
  logic             r_ben, r_bus_err_sticky;
  logic [11:0]      r_led;

  logic [WIDTH-1:0] w_sr1, w_sr2, w_alu_b, w_alu;
  logic [WIDTH-1:0] w_addr1, w_addr2, w_addr_sum, w_bus, w_pc_next;
  logic [2:0]       w_sr1_addr, w_dr_addr, w_nzp_next;
  logic [3:0]       w_gates;
  logic             w_bus_err;

  assign w_sr1_addr = dp.SR1MUX ? r_ir[8:6] : r_ir[11:9];
  assign w_dr_addr  = dp.DRMUX ? 3'd7 : r_ir[11:9];

  slc3_reg_file #(.WIDTH(WIDTH)) u_reg_file (
    .clk        (Clk),
    .rst_n      (Reset),
    .i_we       (dp.LD_REG),
    .i_waddr    (w_dr_addr),
    .i_wdata    (w_bus),
    .i_raddr1   (w_sr1_addr),
    .i_raddr2   (r_ir[2:0]),
    .o_rdata1_c (w_sr1),
    .o_rdata2_c (w_sr2)
  );

  always_comb begin : alu
    w_alu_b = dp.SR2MUX ? WIDTH'(sext(SEXT_W'(r_ir[4:0]), 5)) : w_sr2;
    w_alu   = w_sr1;
    case (alu_op_t'(dp.ALUK))
      ALU_ADD:   w_alu = w_sr1 + w_alu_b;
      ALU_AND:   w_alu = w_sr1 & w_alu_b;
      ALU_NOT:   w_alu = ~w_sr1;
      ALU_PASSA: w_alu = w_sr1;
      default:   w_alu = w_sr1;
    endcase
  end

  always_comb begin : addr_adder
    w_addr1 = dp.ADDR1MUX ? w_sr1 : r_pc;
    w_addr2 = '0;
    case (addr2mux_t'(dp.ADDR2MUX))
      A2_ZERO:  w_addr2 = '0;
      A2_OFF6:  w_addr2 = WIDTH'(sext(SEXT_W'(r_ir[5:0]), 6));
      A2_OFF9:  w_addr2 = WIDTH'(sext(SEXT_W'(r_ir[8:0]), 9));
      A2_OFF11: w_addr2 = WIDTH'(sext(SEXT_W'(r_ir[10:0]), 11));
      default:  w_addr2 = '0;
    endcase
    w_addr_sum = w_addr1 + w_addr2;
  end

  // Bus mux: any gate combination other than a single one-hot source drives zero.
  always_comb begin : bus_mux
    w_gates   = {dp.GateMARMUX, dp.GateALU, dp.GateMDR, dp.GatePC};
    w_bus_err = (w_gates & (w_gates - 4'd1)) != 4'd0;
    w_bus     = '0;
    case (w_gates)
      SRC_PC:     w_bus = r_pc;
      SRC_MDR:    w_bus = r_mdr;
      SRC_ALU:    w_bus = w_alu;
      SRC_MARMUX: w_bus = w_addr_sum;
      default:    w_bus = '0;
    endcase
  end

  always_comb begin : next_values
    w_pc_next = r_pc;
    case (pcmux_t'(dp.PCMUX))
      PC_INC:  w_pc_next = r_pc + WIDTH'(1);
      PC_BUS:  w_pc_next = w_bus;
      PC_ADDR: w_pc_next = w_addr_sum;
      PC_HOLD: w_pc_next = r_pc;
      default: w_pc_next = r_pc;
    endcase
    if (w_bus[WIDTH-1])      w_nzp_next = 3'b100;
    else if (w_bus == '0)    w_nzp_next = 3'b010;
    else                     w_nzp_next = 3'b001;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc             <= PC_RESET;
      r_mar            <= '0;
      r_mdr            <= '0;
      r_ir             <= '0;
      r_nzp            <= NZP_RESET;
      r_ben            <= 1'b0;
      r_led            <= '0;
      r_bus_err_sticky <= 1'b0;
    end else begin
      if (dp.LD_PC)  r_pc  <= w_pc_next;
      if (dp.LD_MAR) r_mar <= w_bus;
      if (dp.LD_MDR) r_mdr <= dp.MIO_EN ? dp.MDR_In : w_bus;
      if (dp.LD_IR)  r_ir  <= w_bus;
      if (dp.LD_CC)  r_nzp <= w_nzp_next;
      if (dp.LD_BEN) r_ben <= |(r_ir[11:9] & r_nzp);
      if (dp.LD_LED) r_led <= r_ir[11:0];
      if (w_bus_err) r_bus_err_sticky <= 1'b1;
    end
  end

  assign dp.Bus          = w_bus;
  assign dp.BusErr       = w_bus_err;
  assign dp.PC           = r_pc;
  assign dp.MAR          = r_mar;
  assign dp.MDR          = r_mdr;
  assign dp.IR           = r_ir;
  assign dp.BEN          = r_ben;
  assign dp.LED          = r_led;
  assign dp.BusErrSticky = r_bus_err_sticky;
endmodule

// File: doc/slc3_datapath_p.md
# slc3_datapath_p

Parametrised successor to the SLC-3 datapath. It holds the architectural state of the LC-3 core: PC, IR, MAR, MDR, an 8-entry register file, NZP condition codes, BEN and the LED latch. All state updates under the control signals issued by the ISDU each cycle. The CPU bus is an internal multiplexer with bus-conflict detection, not a tristate net; the block sits between the ISDU and the Mem2IO/SRAM interface.

## Interface
- WIDTH, 16, datapath width; must be ≥ 16. IR fields keep their LC-3 bit positions, and immediates sign-extend to WIDTH.
- PC_RESET, 0, PC value after reset (WIDTH bits).
- Clk  in  1  sole clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus source selects; at most one may be high.
- PCMUX, ADDR2MUX, ALUK  in  2 each  mux/op selects.
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN  in  1 each  mux selects.
- MDR_In  in  WIDTH  read data from Mem2IO.
- Bus  out  WIDTH  current CPU bus value (combinational).
- MAR, MDR, IR, PC  out  WIDTH each  register contents.
- BEN  out  1  branch-enable register.
- LED  out  12  LED latch.
- BusErr  out  1  combinational; high while more than one Gate is high.
- BusErrSticky  out  1  registered; set on any clock edge with BusErr high; cleared only by reset.

## Operation
- **Bus:** exactly one Gate high selects PC, MDR, ALU or MARMUX. No Gate high gives Bus = 0. More than one Gate high gives Bus = 0 and BusErr = 1.
- **Address adder:** ADDR_sum = ADDR1 + ADDR2, mod 2^WIDTH. MARMUX = ADDR_sum.
  - ADDR1MUX: 0 = PC, 1 = SR1 out.
  - ADDR2MUX: 0 = zero, 1 = SEXT(IR[5:0]), 2 = SEXT(IR[8:0]), 3 = SEXT(IR[10:0]).
- **PC:** loads only when LD_PC is high. PCMUX: 0 = PC+1, 1 = Bus, 2 = ADDR_sum, 3 = hold. Wraps from all-ones to 0.
- **Register file:** 8 × WIDTH.
  - SR1 address: SR1MUX 0 = IR[11:9], 1 = IR[8:6]. SR2 address = IR[2:0].
  - DR: DRMUX 0 = IR[11:9], 1 = 3'd7.
  - Reads are asynchronous. The write (Bus → R[DR]) happens at the edge when LD_REG is high.
  - A read in the same cycle as a write returns the pre-edge value.
- **ALU:** A = SR1 out. B = SR2MUX 0 ? SR2 out : SEXT(IR[4:0]). ALUK: 0 ADD (mod 2^WIDTH), 1 AND, 2 NOT A, 3 PASS A.
- **MAR / IR:** each loads Bus on its own load enable.
- **MDR:** loads on LD_MDR; MIO_EN 1 = MDR_In, 0 = Bus.
- **CC:** loads on LD_CC from Bus. N = Bus[WIDTH-1]; Z = (Bus == 0); P = neither. Exactly one of N, Z, P is set at all times.
- **BEN:** loads on LD_BEN with |(IR[11:9] & {N,Z,P}), using the registered NZP and IR.
- **LED:** loads IR[11:0] on LD_LED.
- **Simultaneous events:** every register samples pre-edge values. Examples:
  - LD_IR with LD_BEN: BEN uses the old IR.
  - LD_CC with LD_BEN: BEN uses the old NZP.
  - LD_PC (PCMUX 1) with GatePC: PC reloads its own value.
- **Conflict cycle:** all loads proceed with Bus = 0. BusErrSticky sets at that edge.

## Timing
- Bus, BusErr, ALU and ADDR_sum are combinational, with zero-cycle latency from their inputs.
- Every register updates at the rising Clk edge where its load is high; its outputs show the new value one cycle later.
- Reset low forces immediately, independent of Clk:
  - PC = PC_RESET
  - MAR, MDR, IR and R0–R7 = 0
  - NZP = 3'b010
  - BEN, LED, BusErrSticky = 0
- Reset asserted mid-instruction discards all in-flight state.
- Reset release is synchronised to Clk upstream. The first load takes effect at the first rising edge after release.

## Structure
- Package slc3_pkg holds:
  - enums pcmux_t, addr2mux_t, alu_op_t (ADD, AND, NOT, PASSA);
  - bus-source one-hot constants;
  - a sext function parameterised on source width.
- Sub-module slc3_reg_file (parameter WIDTH): 8 entries, two async read ports, one write port, async active-low reset.
- Everything else is flat in slc3_datapath_p.

## Test plan
- **Reset:** hold Reset low with Clk running and all loads high; release. Require PC = PC_RESET, NZP = 010, BEN = 0, and all registers 0. Then one cycle of LD_PC with PCMUX = 0 gives PC = PC_RESET+1.
- **ADD immediate:** IR = 16'h1261 (ADD R1,R1,#1) with R1 = 16'h7FFF; assert GateALU, LD_REG, LD_CC. Require R1 = 16'h8000 and NZP = 100.
- **Branch:** NZP = 010; load IR = 16'h0403 (BRz +3) with LD_BEN in a later cycle. Require BEN = 1. Then PCMUX = 2, ADDR1MUX = 0, ADDR2MUX = 2 from PC = 16'h3001 gives PC = 16'h3004.
- **Simultaneous CC/BEN:** NZP = 001, IR[11:9] = 001, Bus = 0; assert LD_CC and LD_BEN in the same cycle. Require BEN = 1 (old P) and NZP = 010.
- **Bus conflict:** raise GatePC and GateMDR together with LD_MAR. Require Bus = 0, BusErr = 1, MAR = 0 after the edge, and BusErrSticky = 1 until reset.
- **Width generality:** run at WIDTH = 32 with IR = 32'h0000_0FFF and ADDR2MUX = 3 from PC = 32'h1000. Require ADDR_sum = 32'h0FFF; SEXT(IR[10:0]) = 32'hFFFF_FFFF.
